fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage sitting directly upstream of the PC register and downstream of instruction memory. Computes the next PC (sequential increment, branch/jump redirect, or hold on stall) and returns it to the PC register's input. It also tracks the in-flight fetch from the synchronous-read instruction ROM and presents a valid/PC/instruction triple to decode. A skid buffer keeps the fetched instruction intact while decode stalls.

## Interface
- ADDR_W, 16, PC and instruction-address width.
- INSTR_W, 32, instruction width.
- PC_STEP, 4, sequential PC increment.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- pc_q  in  ADDR_W  current PC, taken from the PC register output.
- pc_next  out  ADDR_W  next PC, driven to the PC register input.
- imem_addr  out  ADDR_W  ROM read address; equals pc_q (combinational).
- imem_rdata  in  INSTR_W  ROM data, valid one cycle after its address.
- stall  in  1  decode cannot accept; hold the current fetch.
- redirect_valid  in  1  taken branch/jump from execute.
- redirect_target  in  ADDR_W  redirect destination.
- ifid_valid  out  1  decode payload is valid.
- ifid_pc  out  ADDR_W  PC of the presented instruction.
- ifid_instr  out  INSTR_W  presented instruction; INSTR_NOP when ifid_valid=0.

## Operation
- State: f_pc_q (PC whose data is on imem_rdata), f_valid_q, hold_q (INSTR_W), FSM {RUN, HOLD}.
- Per-cycle priority: reset > redirect_valid > stall > advance.
- Advance (no redirect, no stall):
  - pc_next = pc_q + PC_STEP, modulo 2^ADDR_W; wrap 0xFFFC -> 0x0000 is silent.
  - f_pc_q <= pc_q; f_valid_q <= 1; FSM <= RUN.
- Stall (no redirect):
  - pc_next = pc_q; f_pc_q and f_valid_q are held.
  - In RUN: hold_q <= imem_rdata, FSM <= HOLD.
  - In HOLD: hold_q unchanged.
- Redirect (overrides stall):
  - pc_next = redirect_target; f_valid_q <= 0, which flushes the in-flight fetch and the stalled decode instruction.
  - FSM <= RUN.
- Outputs:
  - ifid_pc = f_pc_q.
  - ifid_valid = f_valid_q.
  - ifid_instr = INSTR_NOP if !f_valid_q; otherwise hold_q in HOLD, imem_rdata in RUN.
- Stall while f_valid_q=0: legal. FSM still enters HOLD, but ifid_instr stays NOP.

## Timing
- Reset values: f_pc_q=0, f_valid_q=0, hold_q=0, FSM=RUN.
- Outputs during reset: ifid_valid=0, ifid_pc=0, ifid_instr=INSTR_NOP; pc_next=pc_q+PC_STEP.
- Reset asserted mid-stall or mid-redirect clears all state immediately (asynchronous). There are no pending effects after release.
- Fetch latency: an address presented in cycle n appears on ifid_* in cycle n+1.
- Throughput: one instruction per cycle without stall.
- Redirect penalty: exactly one bubble (ifid_valid=0 in the cycle after redirect).
- Stall release: the held instruction is presented in the release cycle. The next sequential instruction follows one cycle later with no bubble.
- pc_next and imem_addr are combinational from pc_q, stall, and redirect inputs. The block adds no extra register on that path.

## Configuration
- FETCH_PERF_CNT_EN defined:
  - adds outputs fetch_count[31:0] and bubble_count[31:0].
  - fetch_count increments when ifid_valid && !stall.
  - bubble_count increments when !ifid_valid.
  - Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters are absent; the behaviour above is unchanged.

## Structure
- Shared package cpu_pkg holds:
  - ADDR_W/INSTR_W defaults.
  - INSTR_NOP (all zeros).
  - fetch_state_t enum {RUN, HOLD}.
- One sub-module, fetch_skid_buffer, holds hold_q, the FSM, and the output mux. fetch_stage keeps the next-PC logic and the f_pc_q/f_valid_q registers.

## Test plan
- Reset release, ROM word k = 0x1000_0000+k, no stall: ifid_valid rises one cycle after release. ifid_pc runs 0,4,8,C with matching instructions; pc_next leads pc_q by 4.
- Stall 3 cycles while ifid_pc=0x0008: ifid_pc/ifid_instr hold 0x0008/0x1000_0002 for all 3 cycles and pc_next=pc_q=0x000C. After release, 0x000C follows with no bubble.
- Redirect to 0x0100 while at 0x0010: one cycle with ifid_valid=0 and ifid_instr=INSTR_NOP, then ifid_pc=0x0100, 0x0104.
- Redirect to 0x0040 asserted together with stall during a HOLD: stalled instruction is flushed, FSM returns to RUN, next valid ifid_pc=0x0040.
- pc_q=0xFFFC, advance: pc_next=0x0000 and ifid_pc sequence FFFC, 0000.
- Async reset asserted mid-HOLD, between clock edges: ifid_valid drops immediately, with FETCH_PERF_CNT_EN both counters read 0, and the restart sequence matches the first scenario.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default widths, the NOP encoding and the fetch skid-buffer state type.
package cpu_pkg;
  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;

  localparam logic [INSTR_W-1:0] INSTR_NOP = '0;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } fetch_state_t;
endpackage

// File: rtl/fetch_skid_buffer.sv
// Fetch skid buffer: captures the ROM word when decode stalls and selects what decode sees.
// state | meaning
// RUN   | decode sees imem_rdata directly
// HOLD  | decode sees hold_q, the word captured on the first stalled cycle
module fetch_skid_buffer #(
  parameter int INSTR_W = cpu_pkg::INSTR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic               f_valid_q,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] ifid_instr
);
  import cpu_pkg::*;

  fetch_state_t       state_q, state_d;
  logic [INSTR_W-1:0] hold_q, hold_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (redirect_valid) begin
      state_d = RUN;
    end else if (stall) begin
      state_d = HOLD;
      // Only the first stalled cycle captures; later cycles keep that word.
      if (state_q == RUN) hold_d = imem_rdata;
    end else begin
      state_d = RUN;
    end

    if (!f_valid_q)              ifid_instr = INSTR_W'(INSTR_NOP);
    else if (state_q == HOLD)    ifid_instr = hold_q;
    else                         ifid_instr = imem_rdata;
  end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: next-PC selection and in-flight fetch tracking toward decode.
// Optional FETCH_PERF_CNT_EN adds fetch_count/bubble_count performance counters.
module fetch_stage #(
  parameter int ADDR_W  = cpu_pkg::ADDR_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W,
  parameter int PC_STEP = cpu_pkg::PC_STEP
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_q,
  output logic [ADDR_W-1:0]  pc_next,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               ifid_valid,
  output logic [ADDR_W-1:0]  ifid_pc,
  output logic [INSTR_W-1:0] ifid_instr
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_count,
  output logic [31:0]        bubble_count
`endif
);
  logic [ADDR_W-1:0] f_pc_q, f_pc_d;
  logic              f_valid_q, f_valid_d;

  assign imem_addr  = pc_q;
  assign ifid_pc    = f_pc_q;
  assign ifid_valid = f_valid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_pc_q    <= '0;
      f_valid_q <= 1'b0;
    end else begin
      f_pc_q    <= f_pc_d;
      f_valid_q <= f_valid_d;
    end
  end

  // Priority: reset > redirect > stall > advance; increment wraps silently.
  always_comb begin
    pc_next   = pc_q + ADDR_W'(PC_STEP);
    f_pc_d    = f_pc_q;
    f_valid_d = f_valid_q;
    if (reset) begin
      pc_next = pc_q + ADDR_W'(PC_STEP);
    end else if (redirect_valid) begin
      pc_next   = redirect_target;
      f_valid_d = 1'b0;
    end else if (stall) begin
      pc_next = pc_q;
    end else begin
      f_pc_d    = pc_q;
      f_valid_d = 1'b1;
    end
  end

  fetch_skid_buffer #(
    .INSTR_W(INSTR_W)
  ) u_skid (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .f_valid_q     (f_valid_q),
    .imem_rdata    (imem_rdata),
    .ifid_instr    (ifid_instr)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] bubble_count_q, bubble_count_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count_q  <= '0;
      bubble_count_q <= '0;
    end else begin
      fetch_count_q  <= fetch_count_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  always_comb begin
    fetch_count_d  = fetch_count_q;
    bubble_count_d = bubble_count_q;
    if (f_valid_q && !stall) fetch_count_d  = fetch_count_q + 32'd1;
    if (!f_valid_q)          bubble_count_d = bubble_count_q + 32'd1;
  end

  assign fetch_count  = fetch_count_q;
  assign bubble_count = bubble_count_q;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed stall/redirect/wrap/async-reset sequences.
module tb_fetch_stage;
  import cpu_pkg::*;

  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pc_q;
  logic [15:0] pc_next;
  logic [15:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_target = '0;
  logic        ifid_valid;
  logic [15:0] ifid_pc;
  logic [31:0] ifid_instr;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] bubble_count;
`endif

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .pc_q           (pc_q),
    .pc_next        (pc_next),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .ifid_valid     (ifid_valid),
    .ifid_pc        (ifid_pc),
    .ifid_instr     (ifid_instr)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count    (fetch_count),
    .bubble_count   (bubble_count)
`endif
  );

  function automatic logic [31:0] rom_word(input logic [15:0] a);
    return 32'h1000_0000 + {18'd0, a[15:2]};
  endfunction

  always #5 clk = ~clk;

  // PC register and synchronous-read ROM around the stage.
  always @(posedge clk or posedge reset) begin
    if (reset) pc_q <= '0;
    else       pc_q <= pc_next;
  end

  always @(posedge clk) imem_rdata <= rom_word(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = rom_word(pc);
    exp_q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic bubble(input string name);
    chk({name, "_valid"}, {31'd0, ifid_valid}, 32'd0);
    chk({name, "_instr"}, ifid_instr, 32'd0);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && ifid_valid && !stall) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_fetch: got pc %h, expected no fetch", ifid_pc);
        end else begin
          e = exp_q.pop_front();
          chk("fetch_pc", {16'd0, ifid_pc}, {16'd0, e.pc});
          chk("fetch_instr", ifid_instr, e.instr);
        end
      end
    end
  endtask

  initial begin
    fork
      monitor();
      begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
      end
    join_none

    // Reset values
    @(negedge clk);
    bubble("rst");
    chk("rst_pc", {16'd0, ifid_pc}, 32'h0);
    chk("rst_pc_next", {16'd0, pc_next}, 32'h4);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_fetch_count", fetch_count, 32'd0);
    chk("rst_bubble_count", bubble_count, 32'd0);
`endif

    // Sequential fetch, then a 3-cycle stall at 0x0008
    push(16'h0000); push(16'h0004); push(16'h0008); push(16'h000C); push(16'h0010);
    next_cycle(); reset = 1'b0;
    @(negedge clk); bubble("s1_first");
    chk("s1_pc_next0", {16'd0, pc_next}, 32'h4);
    next_cycle(); @(negedge clk);
    chk("s1_pc_next1", {16'd0, pc_next}, 32'h8);
    next_cycle(); @(negedge clk);
    chk("s1_pc_next2", {16'd0, pc_next}, 32'hC);
    next_cycle(); stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_pc", {16'd0, ifid_pc}, 32'h8);
      chk("stall_instr", ifid_instr, 32'h1000_0002);
      chk("stall_pc_next", {16'd0, pc_next}, 32'hC);
      chk("stall_pc_q", {16'd0, pc_q}, 32'hC);
      next_cycle();
    end
    stall = 1'b0;
    @(negedge clk);
    chk("release_pc", {16'd0, ifid_pc}, 32'h8);
    next_cycle(); @(negedge clk);
    chk("release_no_bubble", {31'd0, ifid_valid}, 32'd1);

    // Redirect to 0x0100 while presenting 0x0010
    next_cycle(); redirect_valid = 1'b1; redirect_target = 16'h0100;
    @(negedge clk);
    chk("redir_pc_next", {16'd0, pc_next}, 32'h0100);
    next_cycle(); redirect_valid = 1'b0;
    push(16'h0100); push(16'h0104);
    @(negedge clk); bubble("redir");
    next_cycle(); @(negedge clk);
    next_cycle(); @(negedge clk);

    // Redirect during HOLD flushes the stalled instruction
    next_cycle(); stall = 1'b1;
    @(negedge clk);
    chk("hold_pc", {16'd0, ifid_pc}, 32'h0108);
    next_cycle(); redirect_valid = 1'b1; redirect_target = 16'h0040;
    @(negedge clk);
    chk("hold_instr", ifid_instr, rom_word(16'h0108));
    chk("hold_redir_pc_next", {16'd0, pc_next}, 32'h0040);
    next_cycle(); redirect_valid = 1'b0; stall = 1'b0;
    push(16'h0040); push(16'h0044);
    @(negedge clk); bubble("flush");
    next_cycle(); @(negedge clk);

    // Wrap from 0xFFFC to 0x0000
    next_cycle(); redirect_valid = 1'b1; redirect_target = 16'hFFFC;
    @(negedge clk);
    next_cycle(); redirect_valid = 1'b0;
    push(16'hFFFC); push(16'h0000);
    @(negedge clk); bubble("wrap");
    chk("wrap_pc_q", {16'd0, pc_q}, 32'hFFFC);
    chk("wrap_pc_next", {16'd0, pc_next}, 32'h0000);
    next_cycle(); @(negedge clk);
    chk("wrap_after_pc_next", {16'd0, pc_next}, 32'h0004);
    next_cycle(); @(negedge clk);

    // Async reset in the middle of a HOLD
    next_cycle(); stall = 1'b1;
    @(negedge clk);
    chk("pre_rst_pc", {16'd0, ifid_pc}, 32'h0004);
    next_cycle();
    #2 reset = 1'b1;
    #1;
    bubble("async_rst");
    chk("async_rst_pc", {16'd0, ifid_pc}, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("async_rst_fetch_count", fetch_count, 32'd0);
    chk("async_rst_bubble_count", bubble_count, 32'd0);
`endif
    stall = 1'b0;
    @(negedge clk);
    chk("async_rst_pc_next", {16'd0, pc_next}, 32'h4);

    // Restart matches the first sequence
    push(16'h0000); push(16'h0004); push(16'h0008);
    next_cycle(); reset = 1'b0;
    @(negedge clk); bubble("restart");
    next_cycle(); @(negedge clk);
    next_cycle(); @(negedge clk);
    next_cycle(); @(negedge clk);
    next_cycle();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("end_fetch_count", fetch_count, 32'd3);
    chk("end_bubble_count", bubble_count, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
